// File: rtl/pin_entry.sv
// Keypad front end: buffers two digits into an 8-bit PIN, compares each half against
// the stored PIN, and handles reprogramming, entry timeout, post-submit hold and alarm lockout.
module pin_entry #(
  parameter logic [7:0] DEFAULT_PIN = 8'h42,
  parameter int         TIMEOUT_CYC = 1000,
  parameter int         HOLD_CYC    = 4,
  parameter int         LOCKOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       prog_en,
  input  logic       lock_open_in,
  input  logic       alarm_in,
  output logic [7:0] pin,
  output logic       first_four_match,
  output logic       last_four_match,
  output logic       req_access,
  output logic       pin_updated,
  output logic       entry_err,
  output logic [1:0] digit_cnt,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_HOLD, S_LOCKOUT} state_t;

  localparam int TW      = $clog2(TIMEOUT_CYC + 1);
  localparam int BLK_MAX = (LOCKOUT_CYC > HOLD_CYC) ? LOCKOUT_CYC : HOLD_CYC;
  localparam int BW      = $clog2(BLK_MAX + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] HOLD_LD = BW'(HOLD_CYC);
  localparam logic [BW-1:0] LOCK_LD = BW'(LOCKOUT_CYC);

  state_t          state_q, state_d;
  logic [7:0]      entry_q, stored_q, pin_q;
  logic [1:0]      dcnt_q;
  logic [TW-1:0]   to_cnt_q;
  logic [BW-1:0]   blk_cnt_q;
  logic            first_q, last_q, req_q, upd_q, err_q;

  logic take, dig, clr, ent;
  logic do_shift, do_drop, do_submit, do_prog, do_err, timeout;

  // Key decode; alarm_in suppresses every key action in the same cycle.
  always_comb begin
    take      = key_valid && !alarm_in && (state_q == S_IDLE || state_q == S_ENTRY);
    dig       = take && (key_code <= 4'd9);
    clr       = take && (key_code == 4'hA);
    ent       = take && (key_code == 4'hB);
    do_shift  = dig && (dcnt_q != 2'd2);
    do_drop   = dig && (dcnt_q == 2'd2);
    do_submit = ent && (dcnt_q == 2'd2) && !prog_en;
    do_prog   = ent && (dcnt_q == 2'd2) && prog_en && lock_open_in;
    do_err    = do_drop || (ent && !do_submit && !do_prog);
    timeout   = (state_q == S_ENTRY) && !alarm_in && !(dig || clr || ent) &&
                (to_cnt_q >= TO_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (do_shift)              state_d = S_ENTRY;
        else if (do_submit)        state_d = S_HOLD;
        else if (clr || ent)       state_d = S_IDLE;
        else if (timeout)          state_d = S_IDLE;
      end
      S_HOLD, S_LOCKOUT: begin
        if (blk_cnt_q <= BW'(1))   state_d = S_IDLE;
      end
      default:                     state_d = S_IDLE;
    endcase
    if (alarm_in) state_d = S_LOCKOUT;
  end

  always_comb begin
    busy             = (state_q == S_HOLD) || (state_q == S_LOCKOUT);
    digit_cnt        = dcnt_q;
    pin              = pin_q;
    first_four_match = first_q;
    last_four_match  = last_q;
    req_access       = req_q;
    pin_updated      = upd_q;
    entry_err        = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q   <= '0;
      dcnt_q    <= '0;
      to_cnt_q  <= '0;
      blk_cnt_q <= '0;
      stored_q  <= DEFAULT_PIN;
      pin_q     <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      req_q     <= 1'b0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      req_q <= do_submit;
      upd_q <= do_prog;
      err_q <= do_err;
      if (alarm_in) begin
        entry_q  <= '0;
        dcnt_q   <= '0;
        to_cnt_q <= '0;
      end else if (do_shift) begin
        entry_q  <= {entry_q[3:0], key_code};
        dcnt_q   <= dcnt_q + 2'd1;
        to_cnt_q <= '0;
      end else if (do_drop) begin
        to_cnt_q <= '0;
      end else if (clr || ent || timeout) begin
        entry_q  <= '0;
        dcnt_q   <= '0;
        to_cnt_q <= '0;
      end else if (state_q == S_ENTRY) begin
        if (to_cnt_q != TO_LAST) to_cnt_q <= to_cnt_q + TW'(1);
      end else begin
        to_cnt_q <= '0;
      end
      // Shared block counter: loaded on entry to HOLD/LOCKOUT, saturating down-count.
      if (alarm_in)                  blk_cnt_q <= LOCK_LD;
      else if (do_submit)            blk_cnt_q <= HOLD_LD;
      else if (blk_cnt_q != '0)      blk_cnt_q <= blk_cnt_q - BW'(1);
      if (do_submit) begin
        pin_q   <= entry_q;
        first_q <= (entry_q[7:4] == stored_q[7:4]);
        last_q  <= (entry_q[3:0] == stored_q[3:0]);
      end
      if (do_prog) stored_q <= entry_q;
    end
  end

endmodule
